// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 memory responder: I/O address,
// FSM state encoding and address classification.
package slc3_pkg;

  // Memory-mapped I/O location: switches on read, hex display on write.
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  // Number of meaningful words in the built-in program image.
  localparam logic [15:0] PROG_LEN = 16'd6;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    RD1    = 3'd2,
    RD2    = 3'd3,
    WR_ACK = 3'd4
  } mem_state_t;

  // Where an access lands: block RAM, the I/O register, or nowhere.
  typedef enum logic [1:0] {
    ACC_RAM  = 2'd0,
    ACC_IO   = 2'd1,
    ACC_NONE = 2'd2
  } acc_kind_t;

  // RAM only decodes addresses whose bits above the RAM width are zero.
  function automatic acc_kind_t classify_addr(input logic [15:0] addr, input int addr_w);
    acc_kind_t kind;
    if (addr == IO_ADDR) begin
      kind = ACC_IO;
    end else if ((addr >> addr_w) == 16'h0000) begin
      kind = ACC_RAM;
    end else begin
      kind = ACC_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/slc3_mem_responder_program_rom.sv
// Combinational program image copied into RAM after reset.
// Program: clear R0, then loop incrementing R0 and storing it
// indirectly (through word 5) to the hex display at IO_ADDR.
module program_rom
  import slc3_pkg::*;
(
  input  logic [15:0] idx_i,
  output logic [15:0] word_o
);

  // Table lookup; every index past the program image reads as zero.
  always_comb begin
    word_o = 16'h0000;
    if (idx_i < PROG_LEN) begin
      case (idx_i[2:0])
        3'd0:    word_o = 16'h5020;  // AND R0,R0,#0
        3'd1:    word_o = 16'h1021;  // ADD R0,R0,#1
        3'd2:    word_o = 16'hB002;  // STI R0,#2  (pointer at word 5)
        3'd3:    word_o = 16'h0FFD;  // BRnzp #-3  (back to word 1)
        3'd4:    word_o = 16'h0000;
        3'd5:    word_o = IO_ADDR;   // pointer to the hex display
        default: word_o = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: loads a program image into block RAM after
// reset, then serves single-outstanding read/write requests against RAM
// and one memory-mapped I/O location (switches in, hex display out).
//
// Request/response handshake: a request is taken on a rising edge where
// mem_mem_ena=1, the FSM is IDLE and mem_ready is not currently high.
// Requests at any other time are dropped, never queued. Every taken
// request produces exactly one single-cycle mem_ready pulse: in the cycle
// after the accept edge for writes, and three cycles after the request
// cycle for reads (mem_rdata valid in that same cycle). Blocking accepts
// during a read's ready cycle keeps two pulses from ever being adjacent.
module slc3_mem_responder
  import slc3_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int ROM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        init_done,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output mem_state_t  dbg_state_o
);

  localparam int              IDX_W     = $clog2(ROM_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(ROM_WORDS);
  localparam int              RAM_DEPTH = 1 << ADDR_W;

  mem_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  acc_kind_t         kind_q, kind_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [15:0]       io_q, io_d;
  logic [15:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              init_done_q, init_done_d;
  logic [15:0]       hex_q, hex_d;

  logic              accept;
  acc_kind_t         req_kind;
  logic [15:0]       rom_word;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_q [RAM_DEPTH];
  logic [15:0]       ram_dout_q;

  program_rom u_rom (
    .idx_i  (16'(idx_q)),
    .word_o (rom_word)
  );

  assign accept   = (state_q == IDLE) && !mem_ready_q && mem_mem_ena;
  assign req_kind = classify_addr(mem_addr, ADDR_W);

  // Single-port read-first block RAM; no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_addr] <= ram_wdata;
    end
    ram_dout_q <= ram_q[ram_addr];
  end

  // Next-state, RAM port steering and output register updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    kind_d      = kind_q;
    raddr_d     = raddr_q;
    io_d        = io_q;
    mem_rdata_d = mem_rdata_q;
    mem_ready_d = 1'b0;
    init_done_d = init_done_q;
    hex_d       = hex_q;
    ram_we      = 1'b0;
    ram_addr    = raddr_q;
    ram_wdata   = mem_wdata;

    case (state_q)
      INIT: begin
        if (idx_q != IDX_END) begin
          ram_we    = 1'b1;
          ram_addr  = ADDR_W'(idx_q);
          ram_wdata = rom_word;
          idx_d     = idx_q + 1'b1;
        end else begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          ram_addr = mem_addr[ADDR_W-1:0];
          if (mem_wr_ena) begin
            // Writes commit on the accept edge; out-of-range ones vanish.
            if (req_kind == ACC_RAM) begin
              ram_we = 1'b1;
            end else if (req_kind == ACC_IO) begin
              hex_d = mem_wdata;
            end
            mem_ready_d = 1'b1;
            state_d     = WR_ACK;
          end else begin
            kind_d  = req_kind;
            raddr_d = mem_addr[ADDR_W-1:0];
            io_d    = sw_i;
            state_d = RD1;
          end
        end
      end
      RD1: begin
        // RAM output register captures the latched address on this edge.
        state_d = RD2;
      end
      RD2: begin
        case (kind_q)
          ACC_RAM: mem_rdata_d = ram_dout_q;
          ACC_IO:  mem_rdata_d = io_q;
          default: mem_rdata_d = 16'h0000;
        endcase
        mem_ready_d = 1'b1;
        state_d     = IDLE;
      end
      WR_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      idx_q       <= '0;
      kind_q      <= ACC_NONE;
      raddr_q     <= '0;
      io_q        <= 16'h0000;
      mem_rdata_q <= 16'h0000;
      mem_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      hex_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      kind_q      <= kind_d;
      raddr_q     <= raddr_d;
      io_q        <= io_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ready_q <= mem_ready_d;
      init_done_q <= init_done_d;
      hex_q       <= hex_d;
    end
  end

  assign mem_rdata   = mem_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign init_done   = init_done_q;
  assign hex_o       = hex_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Testbench for slc3_mem_responder: directed scenarios plus random
// traffic, checked by a queue-based scoreboard against a memory model.
module tb_slc3_mem_responder;
  import slc3_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int ROM_WORDS = 64;
  localparam int RAM_DEPTH = 1 << ADDR_W;
  localparam int W         = 17;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_mem_ena = 1'b0;
  logic        mem_wr_ena = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] sw_i = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        init_done;
  logic [15:0] hex_o;
  mem_state_t  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  slc3_mem_responder #(.ADDR_W(ADDR_W), .ROM_WORDS(ROM_WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_mem_ena (mem_mem_ena),
    .mem_wr_ena  (mem_wr_ena),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .init_done   (init_done),
    .sw_i        (sw_i),
    .hex_o       (hex_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [15:0] model_mem [int];
  int          known_q[$];
  logic [15:0] model_hex = 16'h0000;
  logic [15:0] model_last_rd = 16'h0000;

  function automatic logic [15:0] rom_ref(input int k);
    case (k)
      0:       return 16'h5020;
      1:       return 16'h1021;
      2:       return 16'hB002;
      3:       return 16'h0FFD;
      5:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];      // {is_read, expected mem_rdata}
  int           exp_cyc_q[$];  // cycle in which mem_ready must be seen
  logic [15:0]  exp_hex_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_hex_q.delete();
  endtask

  // Monitor: every mem_ready pulse must match the oldest expected response.
  logic         prev_ready = 1'b0;
  logic [W-1:0] mon_e;
  int           mon_c;
  logic [15:0]  mon_h;
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      check("ready_only_after_init", 32'(init_done), 32'd1);
      check("ready_not_back_to_back", 32'(prev_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: mem_ready=1 at cycle %0d, expected no pending response", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        mon_h = exp_hex_q.pop_front();
        check("ready_cycle", 32'(cyc), 32'(mon_c));
        check(mon_e[16] ? "read_data" : "rdata_hold_on_write", 32'(mem_rdata), 32'(mon_e[15:0]));
        check("hex_o", 32'(hex_o), 32'(mon_h));
      end
    end
    prev_ready = mem_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    int n;
    reset = 1'b1;
    mem_mem_ena = 1'b0;
    flush_sb();
    model_hex = 16'h0000;
    model_last_rd = 16'h0000;
    for (int k = 0; k < ROM_WORDS; k++) begin
      if (!model_mem.exists(k)) known_q.push_back(k);
      model_mem[k] = rom_ref(k);
    end
    @(posedge clk); #1;
    check("reset_state", 32'(dbg_state), 32'(INIT));
    check("reset_ready", 32'(mem_ready), 32'd0);
    check("reset_rdata", 32'(mem_rdata), 32'd0);
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_hex", 32'(hex_o), 32'd0);
    reset = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < ROM_WORDS + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_done_latency", 32'(n), 32'(ROM_WORDS + 1));
  endtask

  // Drives one request for a single cycle; returns just after the accept edge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                       input logic [15:0] sw);
    logic [15:0] exp_rd;
    int a;
    exp_rd = 16'h0000;
    @(negedge clk);
    mem_mem_ena = 1'b1;
    mem_wr_ena  = wr;
    mem_addr    = addr;
    mem_wdata   = data;
    sw_i        = sw;
    if (wr) begin
      if (addr == 16'hFFFF) model_hex = data;
      else if (int'(addr) < RAM_DEPTH) begin
        if (!model_mem.exists(int'(addr))) known_q.push_back(int'(addr));
        model_mem[int'(addr)] = data;
      end
    end else begin
      if (addr == 16'hFFFF) exp_rd = sw;
      else if (int'(addr) < RAM_DEPTH) exp_rd = model_mem[int'(addr)];
      else exp_rd = 16'h0000;
      model_last_rd = exp_rd;
    end
    @(posedge clk); #1;
    a = cyc;
    mem_mem_ena = 1'b0;
    exp_q.push_back(wr ? {1'b0, model_last_rd} : {1'b1, exp_rd});
    exp_cyc_q.push_back(wr ? a : a + 2);
    exp_hex_q.push_back(model_hex);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL response_timeout: %0d responses pending after %0d cycles, expected 0", exp_q.size(), n);
      flush_sb();
    end
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 16'hFFFF));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int idx;
    logic [15:0] a;

    do_reset();

    // Write then read back a RAM word.
    issue(1'b1, 16'h0005, 16'hBEEF, rnd16()); wait_done();
    issue(1'b0, 16'h0005, 16'h0000, rnd16()); wait_done();

    // Switches and hex display at the I/O address.
    issue(1'b0, 16'hFFFF, 16'h0000, 16'h1234); wait_done();
    issue(1'b1, 16'hFFFF, 16'hA5A5, rnd16()); wait_done();

    // Out-of-range address: reads zero, writes do not alias onto word 0.
    issue(1'b0, 16'h0400, 16'h0000, rnd16()); wait_done();
    issue(1'b1, 16'h0400, 16'h7777, rnd16()); wait_done();
    issue(1'b0, 16'h0000, 16'h0000, rnd16()); wait_done();

    // Request held high through RD1/RD2 with another address is dropped.
    issue(1'b0, 16'h0005, 16'h0000, rnd16());
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b1;
    mem_addr    = 16'h0006;
    mem_wdata   = 16'h9999;
    repeat (3) @(posedge clk);
    #1 mem_mem_ena = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    issue(1'b0, 16'h0006, 16'h0000, rnd16()); wait_done();

    // Random traffic.
    repeat (150) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          idx = $urandom_range(0, known_q.size() - 1);
          issue(1'b0, 16'(known_q[idx]), 16'h0000, rnd16());
        end
        3, 4, 5: begin
          a = 16'($urandom_range(0, RAM_DEPTH - 1));
          issue(1'b1, a, rnd16(), rnd16());
        end
        6: issue(1'b0, 16'hFFFF, 16'h0000, rnd16());
        7: issue(1'b1, 16'hFFFF, rnd16(), rnd16());
        8: issue(1'b0, 16'($urandom_range(RAM_DEPTH, 16'hFFFE)), 16'h0000, rnd16());
        default: issue(1'b1, 16'($urandom_range(RAM_DEPTH, 16'hFFFE)), rnd16(), rnd16());
      endcase
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during RD1: no response, program reloaded, upper RAM kept.
    issue(1'b1, 16'h0000, 16'h1111, rnd16()); wait_done();
    issue(1'b1, 16'h0200, 16'hCAFE, rnd16()); wait_done();
    issue(1'b0, 16'h0000, 16'h0000, rnd16());
    do_reset();
    repeat (3) @(posedge clk);
    issue(1'b0, 16'h0000, 16'h0000, rnd16()); wait_done();
    issue(1'b0, 16'h0200, 16'h0000, rnd16()); wait_done();
    issue(1'b0, 16'h0005, 16'h0000, rnd16()); wait_done();

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
